// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op codes, default datapath widths and the ID/EX register layout
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLL = 3'd4;
   localparam logic [2:0] ALU_SRL = 3'd5;
   localparam logic [2:0] ALU_SLT = 3'd6;
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rs;
      logic [ADDR_W-1:0] rt;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic              alusrc;
      logic [2:0]        aluop;
      logic              regwrite;
      logic              memread;
      logic              memwrite;
   } id_ex_t;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: selects the freshest value of one source register (EX/MEM over MEM/WB over register file)
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) (
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data,
   input  logic          exmem_regwrite,
   input  logic [AW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [AW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic [DW-1:0] sel
);
   logic ex_hit, wb_hit;
   always_comb begin
      ex_hit = exmem_regwrite && exmem_rd != '0 && exmem_rd == addr;
      wb_hit = memwb_regwrite && memwb_rd != '0 && memwb_rd == addr;
      sel = ex_hit ? exmem_result : wb_hit ? memwb_result : data;
   end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubble insertion
// Define ID_EX_FORWARD_EN to enable the EX/MEM and MEM/WB forwarding muxes.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [AW-1:0] id_rs_addr,
   input  logic [AW-1:0] id_rt_addr,
   input  logic [AW-1:0] id_rd_addr,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic          id_alusrc,
   input  logic [2:0]    id_aluop,
   input  logic          id_regwrite,
   input  logic          id_memread,
   input  logic          id_memwrite,
   input  logic          exmem_regwrite,
   input  logic [AW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_regwrite,
   input  logic [AW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic          ex_valid,
   output logic [DW-1:0] ex_in1,
   output logic [DW-1:0] ex_in2,
   output logic [2:0]    ex_aluop,
   output logic [DW-1:0] ex_store_data,
   output logic [AW-1:0] ex_rd_addr,
   output logic          ex_regwrite,
   output logic          ex_memread,
   output logic          ex_memwrite,
   output logic          load_use_stall
);
   id_ex_t r;
   logic [DW-1:0] fwd_rs, fwd_rt;
   logic reg_hazard;
`ifdef ID_EX_FORWARD_EN
   fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
      .addr(r.rs), .data(r.rs_data),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .sel(fwd_rs)
   );
   fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
      .addr(r.rt), .data(r.rt_data),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .sel(fwd_rt)
   );
   assign reg_hazard = 1'b0;
`else
   // Without forwarding any pending EX write to a source must be waited out
   logic unused_fwd;
   assign fwd_rs = r.rs_data;
   assign fwd_rt = r.rt_data;
   assign reg_hazard = r.regwrite;
   assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd,
                         memwb_result, r.rs, r.rt};
`endif
   always_comb
      load_use_stall = id_valid && r.valid && (r.memread || reg_hazard) && r.rd != '0 &&
                       (r.rd == id_rs_addr || (r.rd == id_rt_addr && !id_alusrc));
   always_ff @(posedge clk)
      if (rst || flush || (!stall && load_use_stall)) r <= '0;
      else if (!stall)
         r <= '{valid: id_valid, rs: id_rs_addr, rt: id_rt_addr, rd: id_rd_addr,
                rs_data: id_rs_data, rt_data: id_rt_data, imm: id_imm, alusrc: id_alusrc,
                aluop: id_aluop, regwrite: id_regwrite, memread: id_memread,
                memwrite: id_memwrite};
   always_comb begin
      ex_valid      = r.valid;
      ex_in1        = fwd_rs;
      ex_in2        = r.alusrc ? r.imm : fwd_rt;
      ex_store_data = fwd_rt;
      ex_aluop      = r.aluop;
      ex_rd_addr    = r.rd;
      ex_regwrite   = r.valid && r.regwrite;
      ex_memread    = r.valid && r.memread;
      ex_memwrite   = r.valid && r.memwrite;
   end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven and sequence checks for id_ex_stage, both forwarding builds
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, stall, flush, id_valid, id_alusrc, id_regwrite, id_memread, id_memwrite;
   logic [4:0] id_rs_addr, id_rt_addr, id_rd_addr, exmem_rd, memwb_rd, ex_rd_addr;
   logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
   logic [2:0] id_aluop, ex_aluop;
   logic exmem_regwrite, memwb_regwrite;
   logic ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_stall;
   logic [31:0] ex_in1, ex_in2, ex_store_data;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_aluop(ex_aluop),
      .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .load_use_stall(load_use_stall)
   );

   typedef struct {
      logic v; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm; logic alusrc;
      logic [2:0] op, ctl;
      logic xw; logic [4:0] xrd; logic [31:0] xres;
      logic ww; logic [4:0] wrd; logic [31:0] wres;
      logic [31:0] f_in1, f_in2, f_st, n_in1, n_in2, n_st; logic [2:0] e_ctl;
   } vec_t;
   typedef struct {
      logic [31:0] in1, in2, st; logic v; logic [2:0] op, ctl; logic [4:0] rd;
   } exp_t;

   vec_t vec[8];
   exp_t sb[$];
   exp_t e;
   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, rt, rd,
                        input logic [31:0] rsd, rtd, imm, input logic alusrc,
                        input logic [2:0] op, input logic [2:0] ctl);
      id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
      id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alusrc = alusrc; id_aluop = op;
      {id_regwrite, id_memread, id_memwrite} = ctl;
   endtask

   task automatic fwd(input logic xw, input logic [4:0] xrd, input logic [31:0] xres,
                      input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
      exmem_regwrite = xw; exmem_rd = xrd; exmem_result = xres;
      memwb_regwrite = ww; memwb_rd = wrd; memwb_result = wres;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " valid"}, 32'(ex_valid), 32'd0);
      chk({tag, " in1"}, ex_in1, 32'd0);
      chk({tag, " in2"}, ex_in2, 32'd0);
      chk({tag, " store"}, ex_store_data, 32'd0);
      chk({tag, " aluop"}, 32'(ex_aluop), 32'd0);
      chk({tag, " rd"}, 32'(ex_rd_addr), 32'd0);
      chk({tag, " ctl"}, 32'({ex_regwrite, ex_memread, ex_memwrite}), 32'd0);
      chk({tag, " lus"}, 32'(load_use_stall), 32'd0);
   endtask

   initial begin
      // v rs rt rd rsd rtd imm alusrc op ctl | xw xrd xres ww wrd wres | fwd in1 in2 st | nofwd in1 in2 st | ctl
      vec[0] = '{1, 1, 0, 2, 10, 0, 5, 1, 0, 3'b100, 0, 0, 0, 0, 0, 0,
                 10, 5, 0, 10, 5, 0, 3'b100};
      vec[1] = '{1, 3, 6, 5, 'h11, 'h22, 0, 0, 1, 3'b100, 1, 3, 'hAA, 1, 3, 'hBB,
                 'hAA, 'h22, 'h22, 'h11, 'h22, 'h22, 3'b100};
      vec[2] = '{1, 3, 6, 5, 'h11, 'h22, 0, 0, 1, 3'b100, 0, 3, 'hAA, 1, 3, 'hBB,
                 'hBB, 'h22, 'h22, 'h11, 'h22, 'h22, 3'b100};
      vec[3] = '{1, 0, 6, 5, 'h33, 'h22, 0, 0, 2, 3'b100, 1, 0, 'hAA, 1, 0, 'hBB,
                 'h33, 'h22, 'h22, 'h33, 'h22, 'h22, 3'b100};
      vec[4] = '{1, 8, 7, 9, 'h88, 'h44, 0, 0, 3, 3'b110, 1, 7, 'h77, 1, 8, 'h66,
                 'h66, 'h77, 'h77, 'h88, 'h44, 'h44, 3'b110};
      vec[5] = '{1, 1, 9, 0, 1, 'h99, 'h1234, 1, 4, 3'b001, 1, 10, 'hCC0, 1, 9, 'hCC,
                 1, 'h1234, 'hCC, 1, 'h1234, 'h99, 3'b001};
      vec[6] = '{0, 2, 3, 7, 'h5A, 'hA5, 'hF0, 0, 5, 3'b111, 0, 0, 0, 0, 0, 0,
                 'h5A, 'hA5, 'hA5, 'h5A, 'hA5, 'hA5, 3'b000};
      vec[7] = '{1, 31, 31, 31, 'hFFFFFFFF, 'h80000000, 'hFFFFFFFF, 0, 6, 3'b100,
                 1, 31, 'h12345678, 1, 31, 'h87654321,
                 'h12345678, 'h12345678, 'h12345678, 'hFFFFFFFF, 'h80000000, 'h80000000, 3'b100};

      stall = 0; flush = 0; rst = 0;
      drive(1, 1, 2, 3, 'h77, 'h88, 'h99, 0, 5, 3'b111);
      fwd(0, 0, 0, 0, 0, 0);
      @(negedge clk); rst = 1;
      @(negedge clk);
      chk_zero("reset");
      rst = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         drive(vec[i].v, vec[i].rs, vec[i].rt, vec[i].rd, vec[i].rsd, vec[i].rtd, vec[i].imm,
               vec[i].alusrc, vec[i].op, vec[i].ctl);
         fwd(0, 0, 0, 0, 0, 0);
         sb.push_back('{FWD ? vec[i].f_in1 : vec[i].n_in1, FWD ? vec[i].f_in2 : vec[i].n_in2,
                        FWD ? vec[i].f_st : vec[i].n_st, vec[i].v, vec[i].op, vec[i].e_ctl,
                        vec[i].rd});
         @(negedge clk);
         id_valid = 0;
         fwd(vec[i].xw, vec[i].xrd, vec[i].xres, vec[i].ww, vec[i].wrd, vec[i].wres);
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d in1", i), ex_in1, e.in1);
         chk($sformatf("v%0d in2", i), ex_in2, e.in2);
         chk($sformatf("v%0d store", i), ex_store_data, e.st);
         chk($sformatf("v%0d valid", i), 32'(ex_valid), 32'(e.v));
         chk($sformatf("v%0d aluop", i), 32'(ex_aluop), 32'(e.op));
         chk($sformatf("v%0d rd", i), 32'(ex_rd_addr), 32'(e.rd));
         chk($sformatf("v%0d ctl", i), 32'({ex_regwrite, ex_memread, ex_memwrite}), 32'(e.ctl));
         chk($sformatf("v%0d lus", i), 32'(load_use_stall), 32'd0);
         @(negedge clk);
      end
      fwd(0, 0, 0, 0, 0, 0);

      // load-use: load r4 in EX, dependent reads r4
      drive(1, 1, 0, 4, 'h100, 0, 0, 1, 0, 3'b110);
      @(negedge clk);
      drive(1, 4, 0, 6, 'h40, 0, 3, 1, 0, 3'b100);
      #1 chk("lu stall", 32'(load_use_stall), 32'd1);
      chk("lu load in EX", 32'(ex_memread), 32'd1);
      @(negedge clk);
      chk("lu bubble valid", 32'(ex_valid), 32'd0);
      chk("lu bubble regwrite", 32'(ex_regwrite), 32'd0);
      chk("lu stall cleared", 32'(load_use_stall), 32'd0);
      @(negedge clk);
      id_valid = 0;
      fwd(0, 0, 0, 1, 4, 'h55);
      #1 chk("lu dep valid", 32'(ex_valid), 32'd1);
      chk("lu dep in1", ex_in1, FWD ? 32'h55 : 32'h40);
      chk("lu dep in2", ex_in2, 32'd3);
      fwd(0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // stall hold, then flush wins over stall
      drive(1, 2, 3, 5, 'h21, 'h31, 7, 0, 3, 3'b101);
      @(negedge clk);
      stall = 1;
      drive(1, 6, 7, 8, 'hDEAD, 'hBEEF, 'h99, 1, 1, 3'b010);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d in1", k), ex_in1, 32'h21);
         chk($sformatf("stall%0d in2", k), ex_in2, 32'h31);
         chk($sformatf("stall%0d ctl", k), 32'({ex_valid, ex_regwrite, ex_memwrite}), 32'b111);
      end
      flush = 1;
      @(negedge clk);
      chk("flush+stall valid", 32'(ex_valid), 32'd0);
      chk("flush+stall regwrite", 32'(ex_regwrite), 32'd0);
      stall = 0; flush = 0;

      // mid-operation reset
      drive(1, 3, 4, 8, 1, 2, 3, 0, 6, 3'b110);
      @(negedge clk);
      id_valid = 0;
      #1 chk("pre-reset valid", 32'(ex_valid), 32'd1);
      rst = 1;
      @(negedge clk);
      chk_zero("midreset");
      rst = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
